// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline: data-memory loads/stores with a
// configurable multi-cycle latency, stall generation, and the MEM/WB register.
module mem_stage #(
    parameter int unsigned MEM_WORDS   = 64,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_en_in,
    input  logic [1:0]  MEM_Signal_in,
    input  logic [4:0]  dest_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] reg2_in,
    output logic        freeze,
    output logic        WB_en_MEM,
    output logic        MEM_R_EN_MEM,
    output logic [4:0]  dest_MEM,
    output logic [31:0] ALU_result_MEM,
    output logic [31:0] mem_data_MEM
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned LAT_M1 = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_store_c;
    logic               is_load_c;
    logic               mem_op_c;
    logic               stall_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   word_idx_c;
    logic [31:0]        rd_data_c;

    logic               wb_en_q, wb_en_d;
    logic               mem_r_en_q, mem_r_en_d;
    logic [4:0]         dest_q, dest_d;
    logic [31:0]        alu_result_q, alu_result_d;
    logic [31:0]        mem_data_q, mem_data_d;

    logic [31:0]        mem_q [MEM_WORDS];

    // Decode the access: a store wins when both enables are set.
    always_comb begin
        is_store_c = MEM_Signal_in[0];
        is_load_c  = MEM_Signal_in[1] & ~MEM_Signal_in[0];
        mem_op_c   = MEM_Signal_in[1] | MEM_Signal_in[0];
        word_idx_c = IDX_W'((ALU_result_in - 32'(ADDR_BASE)) >> 2);
        rd_data_c  = mem_q[word_idx_c];
    end

    // State and latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a new access parks in ACCESS until the counter drains.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op_c && (MEM_LATENCY != 32'd0)) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_W'(LAT_M1);
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: stall request, store strobe and MEM/WB next values.
    always_comb begin
        stall_c      = 1'b0;
        case (state_q)
            S_IDLE:   stall_c = mem_op_c && (MEM_LATENCY != 32'd0);
            S_ACCESS: stall_c = (cnt_q != '0);
            default:  stall_c = 1'b0;
        endcase

        freeze       = stall_c & ~rst;
        mem_we_c     = is_store_c & ~stall_c;

        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        dest_d       = '0;
        alu_result_d = '0;
        mem_data_d   = '0;
        if (!stall_c) begin
            wb_en_d      = WB_en_in;
            mem_r_en_d   = is_load_c;
            dest_d       = dest_in;
            alu_result_d = ALU_result_in;
            mem_data_d   = is_load_c ? rd_data_c : 32'd0;
        end
    end

    // Data memory write port; contents survive reset, and a reset edge
    // suppresses the commit so an interrupted store never lands.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem_q[word_idx_c] <= reg2_in;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            dest_q       <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            dest_q       <= dest_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign WB_en_MEM      = wb_en_q;
    assign MEM_R_EN_MEM   = mem_r_en_q;
    assign dest_MEM       = dest_q;
    assign ALU_result_MEM = alu_result_q;
    assign mem_data_MEM   = mem_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a latency-0 build driven from a vector table
// and a latency-2 build driven through hand-written multi-cycle sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;

    logic        wb2, wb0;
    logic [1:0]  sig2, sig0;
    logic [4:0]  dest2, dest0;
    logic [31:0] alu2, alu0;
    logic [31:0] reg2_2, reg2_0;

    logic        frz2, frz0;
    logic        owb2, owb0;
    logic        orr2, orr0;
    logic [4:0]  odest2, odest0;
    logic [31:0] oalu2, oalu0;
    logic [31:0] odata2, odata0;

    int n_checks;
    int n_errors;

    mem_stage #(.MEM_WORDS(64), .ADDR_BASE(1024), .MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .WB_en_in(wb2), .MEM_Signal_in(sig2), .dest_in(dest2),
        .ALU_result_in(alu2), .reg2_in(reg2_2),
        .freeze(frz2), .WB_en_MEM(owb2), .MEM_R_EN_MEM(orr2),
        .dest_MEM(odest2), .ALU_result_MEM(oalu2), .mem_data_MEM(odata2)
    );

    mem_stage #(.MEM_WORDS(64), .ADDR_BASE(1024), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .WB_en_in(wb0), .MEM_Signal_in(sig0), .dest_in(dest0),
        .ALU_result_in(alu0), .reg2_in(reg2_0),
        .freeze(frz0), .WB_en_MEM(owb0), .MEM_R_EN_MEM(orr0),
        .dest_MEM(odest0), .ALU_result_MEM(oalu0), .mem_data_MEM(odata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb;
        logic [1:0]  sig;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] reg2;
        logic        e_wb;
        logic        e_r;
        logic [4:0]  e_dest;
        logic [31:0] e_alu;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive2(input logic wb, input logic [1:0] sig, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] r);
        wb2 = wb; sig2 = sig; dest2 = d; alu2 = a; reg2_2 = r;
    endtask

    task automatic drive0(input logic wb, input logic [1:0] sig, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] r);
        wb0 = wb; sig0 = sig; dest0 = d; alu0 = a; reg2_0 = r;
    endtask

    task automatic chk_out2(input string nm, input logic e_wb, input logic e_r,
                            input logic [4:0] e_d, input logic [31:0] e_a,
                            input logic [31:0] e_data);
        chk({nm, ".wb"},   32'(owb2),   32'(e_wb));
        chk({nm, ".mr"},   32'(orr2),   32'(e_r));
        chk({nm, ".dest"}, 32'(odest2), 32'(e_d));
        chk({nm, ".alu"},  oalu2,       e_a);
        chk({nm, ".data"}, odata2,      e_data);
    endtask

    // One memory op on the latency-2 build: two stall cycles with bubbles,
    // then the ready cycle and the captured result.
    task automatic op2(input string nm, input logic wb, input logic [1:0] sig,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] r,
                       input logic e_r, input logic [31:0] e_data);
        drive2(wb, sig, d, a, r);
        for (int c = 0; c < 2; c++) begin
            #1 chk({nm, ".frz_stall"}, 32'(frz2), 32'd1);
            @(posedge clk); #1;
            chk_out2({nm, ".bubble"}, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        end
        #1 chk({nm, ".frz_ready"}, 32'(frz2), 32'd0);
        @(posedge clk); #1;
        chk_out2(nm, wb, e_r, d, a, e_data);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //                wb    sig    dest   alu         reg2          e_wb  e_r   e_dest e_alu       e_data
        tbl[0] = '{1'b1, 2'b00, 5'd5,  32'h0000_00AB, 32'h99,       1'b1, 1'b0, 5'd5,  32'h0000_00AB, 32'h0};
        tbl[1] = '{1'b0, 2'b01, 5'd0,  32'd1032,      32'h55,       1'b0, 1'b0, 5'd0,  32'd1032,      32'h0};
        tbl[2] = '{1'b1, 2'b10, 5'd3,  32'd1032,      32'h0,        1'b1, 1'b1, 5'd3,  32'd1032,      32'h55};
        tbl[3] = '{1'b0, 2'b01, 5'd0,  32'd1283,      32'h1234,     1'b0, 1'b0, 5'd0,  32'd1283,      32'h0};
        tbl[4] = '{1'b1, 2'b10, 5'd9,  32'd1024,      32'h0,        1'b1, 1'b1, 5'd9,  32'd1024,      32'h1234};
        tbl[5] = '{1'b0, 2'b11, 5'd0,  32'd1036,      32'h77,       1'b0, 1'b0, 5'd0,  32'd1036,      32'h0};
        tbl[6] = '{1'b1, 2'b10, 5'd12, 32'd1038,      32'h0,        1'b1, 1'b1, 5'd12, 32'd1038,      32'h77};
        tbl[7] = '{1'b1, 2'b01, 5'd4,  32'd1040,      32'hA5A5,     1'b1, 1'b0, 5'd4,  32'd1040,      32'h0};
        tbl[8] = '{1'b1, 2'b10, 5'd31, 32'd1296,      32'h0,        1'b1, 1'b1, 5'd31, 32'd1296,      32'hA5A5};
        tbl[9] = '{1'b1, 2'b00, 5'd1,  32'd1032,      32'h0,        1'b1, 1'b0, 5'd1,  32'd1032,      32'h0};

        // Reset with a pending load on the inputs: freeze must stay low.
        rst = 1'b1;
        drive2(1'b1, 2'b10, 5'd7, 32'd1028, 32'd0);
        drive0(1'b1, 2'b10, 5'd7, 32'd1028, 32'd0);
        #2;
        chk("rst.frz2", 32'(frz2), 32'd0);
        chk("rst.frz0", 32'(frz0), 32'd0);
        @(posedge clk); #1;
        chk_out2("rst.out2", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        chk("rst.wb0", 32'(owb0), 32'd0);
        drive2(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        drive0(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Latency-0 build: every row completes in one edge with no stall.
        for (int i = 0; i < 10; i++) begin
            drive0(tbl[i].wb, tbl[i].sig, tbl[i].dest, tbl[i].alu, tbl[i].reg2);
            #1 chk($sformatf("v%0d.frz", i), 32'(frz0), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d.wb", i),   32'(owb0),   32'(tbl[i].e_wb));
            chk($sformatf("v%0d.mr", i),   32'(orr0),   32'(tbl[i].e_r));
            chk($sformatf("v%0d.dest", i), 32'(odest0), 32'(tbl[i].e_dest));
            chk($sformatf("v%0d.alu", i),  oalu0,       tbl[i].e_alu);
            chk($sformatf("v%0d.data", i), odata0,      tbl[i].e_data);
        end
        drive0(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);

        // Latency-2 build: non-memory op passes straight through.
        drive2(1'b1, 2'b00, 5'd5, 32'h0000_00AB, 32'h0);
        #1 chk("nm.frz", 32'(frz2), 32'd0);
        @(posedge clk); #1;
        chk_out2("nm", 1'b1, 1'b0, 5'd5, 32'h0000_00AB, 32'd0);
        chk("nm.frz_after", 32'(frz2), 32'd0);

        // Store then load, back to back.
        op2("st1028", 1'b0, 2'b01, 5'd0, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'd0);
        op2("ld1028", 1'b1, 2'b10, 5'd7, 32'd1028, 32'd0,         1'b1, 32'hDEAD_BEEF);

        // Wrap and low-bit alignment.
        op2("stwrap", 1'b0, 2'b01, 5'd0, 32'd1283, 32'h1234, 1'b0, 32'd0);
        op2("ld1024", 1'b1, 2'b10, 5'd8, 32'd1024, 32'd0,    1'b1, 32'h1234);

        // Both enables set behaves as a store.
        op2("rw1036", 1'b1, 2'b11, 5'd6, 32'd1036, 32'h77, 1'b0, 32'd0);
        op2("ld1036", 1'b1, 2'b10, 5'd9, 32'd1036, 32'd0,  1'b1, 32'h77);

        // Reset in the middle of a store aborts it.
        op2("st1040", 1'b0, 2'b01, 5'd0, 32'd1040, 32'h1111, 1'b0, 32'd0);
        drive2(1'b0, 2'b01, 5'd0, 32'd1040, 32'hCAFE);
        #1 chk("ab.frz0", 32'(frz2), 32'd1);
        @(posedge clk); #1;
        chk("ab.frz1", 32'(frz2), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ab.frz_rst", 32'(frz2), 32'd0);
        chk_out2("ab.rst", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        drive2(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        @(negedge clk) rst = 1'b0;
        op2("ld1040", 1'b1, 2'b10, 5'd2, 32'd1040, 32'd0, 1'b1, 32'h1111);

        drive2(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS-style pipeline. Sits directly downstream of the Exe stage and consumes its EX/MEM outputs: WB enable, MEM signals, dest, ALU result and reg2.
- Performs data-memory loads/stores with a configurable multi-cycle access latency. Raises a freeze to stall the upstream stages while an access is in flight.
- Registers results into the MEM/WB pipeline register for the WB stage.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the data memory (power of two)
ADDR_BASE, 1024, byte address mapped to word 0
MEM_LATENCY, 2, stall cycles per load/store (0 = single-cycle access, no stall)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
WB_en_in  input  1  WB enable from EX/MEM register
MEM_Signal_in  input  2  bit1 = MEM_R_EN (load), bit0 = MEM_W_EN (store)
dest_in  input  5  destination register from EX/MEM
ALU_result_in  input  32  effective byte address, or ALU value for non-memory ops
reg2_in  input  32  store data
freeze  output  1  combinational stall request to the IF/ID/EXE registers and PC
WB_en_MEM  output  1  registered WB enable
MEM_R_EN_MEM  output  1  registered load flag (WB mux select)
dest_MEM  output  5  registered destination
ALU_result_MEM  output  32  registered ALU result
mem_data_MEM  output  32  registered load data

Behaviour:
- Reset (async, any cycle):
  - state = IDLE, counter = 0.
  - All MEM/WB outputs = 0; freeze = 0 while rst is high.
  - Memory contents are not cleared.
  - A reset mid-access aborts the access; a pending store is not committed.
- Addressing: word index = ((ALU_result_in - ADDR_BASE) >> 2) modulo MEM_WORDS, i.e. the low log2(MEM_WORDS) bits.
  - Low 2 address bits are ignored.
  - Out-of-range addresses wrap; no error is reported.
- mem_op = MEM_R_EN | MEM_W_EN. If both bits are set, the access is a store and the load flag is forwarded as 0.
- FSM, states IDLE and ACCESS, with a latency counter:
  - IDLE, mem_op=0: freeze = 0; the MEM/WB register captures the inputs at the edge.
  - IDLE, mem_op=1, MEM_LATENCY=0:
    - Store commits at the edge.
    - Load data is read combinationally and captured.
    - freeze = 0.
  - IDLE, mem_op=1, MEM_LATENCY>0:
    - freeze = 1.
    - Next state ACCESS, counter <= MEM_LATENCY-1.
    - MEM/WB captures a bubble (WB_en=0, MEM_R_EN=0, dest=0, data fields 0).
  - ACCESS, counter != 0: freeze = 1, counter decrements, MEM/WB captures a bubble.
  - ACCESS, counter == 0 (ready cycle):
    - freeze = 0.
    - Store commits at the edge.
    - Load data is captured into mem_data_MEM; the other inputs are captured normally.
    - Next state IDLE.
- Timing: a memory op first presented in cycle T holds freeze high for cycles T..T+MEM_LATENCY-1. Results appear on the MEM/WB outputs after the edge ending cycle T+MEM_LATENCY.
- Inputs are held stable by the frozen upstream register during the stall; the block does not re-latch them.
- Back-to-back memory ops: the op following a ready cycle enters IDLE with mem_op=1 and stalls afresh. There is no pipelining of accesses.
- Non-memory ops: the mem_data_MEM field is 0.
- A store with WB_en_in=1 is forwarded as-is; suppressing it is the decoder's job.
- Load after store to the same word returns the new value, since the store commits before the later load's ready cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during ACCESS → all outputs 0 and freeze 0 immediately; after release, state IDLE; the aborted store word is unchanged on a later read.
- Non-memory op: WB_en_in=1, MEM_Signal=00, dest=5, ALU_result=0x0000_00AB → next edge: WB_en_MEM=1, dest_MEM=5, ALU_result_MEM=0xAB, mem_data_MEM=0, freeze never high.
- Store then load (MEM_LATENCY=2):
  - Store: addr 1028, reg2=0xDEADBEEF → freeze high for exactly 2 cycles, bubble outputs during the stall.
  - Load: addr 1028, dest=7 → after 2 stall cycles, MEM_R_EN_MEM=1, dest_MEM=7, mem_data_MEM=0xDEADBEEF.
- Wrap/alignment: store 0x1234 at 1024+4*64+3 → a load from 1024 returns 0x1234.
- MEM_LATENCY=0 build: store 0x55 at 1032 then load 1032 on consecutive cycles → freeze stays 0, load result 0x55 one edge later.
- Both R and W set: addr 1036, reg2=0x77 → word written, MEM_R_EN_MEM=0; a subsequent load of 1036 returns 0x77.
